// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges per-stage stall requests and flush requests
// into the stage-hold vector and flush strobe, plus a stall watchdog and stall counter.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES  = 1,
    parameter int STALL_TIMEOUT = 1024,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             flush_req,
    input  logic [31:0]      flush_pc_in,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] perf_stall_cnt
);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    localparam int         WD_W       = $clog2(STALL_TIMEOUT + 1);
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t           state;
    logic [3:0]       flush_cnt;
    logic [31:0]      target;
    logic [WD_W-1:0]  wd_cnt;
    logic             timeout_q;
    logic [CNT_W-1:0] perf_q;
    logic [5:0]       stall_raw;

    // Deepest requesting stage wins; WB is never held.
    always_comb begin
        stall_raw = 6'b000000;
        if (stallreq_mem)
            stall_raw = 6'b011111;
        else if (stallreq_ex)
            stall_raw = 6'b001111;
        else if (stallreq_id)
            stall_raw = 6'b000111;
    end

    // A new flush request overrides everything, including an in-progress flush.
    always_comb begin
        stall  = 6'b000000;
        flush  = 1'b0;
        new_pc = 32'h0;
        if (!rst) begin
            if (flush_req) begin
                flush  = 1'b1;
                new_pc = flush_pc_in;
            end else if (state == FLUSH) begin
                flush  = 1'b1;
                new_pc = target;
            end else begin
                stall = stall_raw;
            end
        end
    end

    assign stall_timeout  = !rst && timeout_q;
    assign perf_stall_cnt = rst ? '0 : perf_q;

    // flush_cnt holds the number of FLUSH-state cycles still to run, including the current one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= 4'd0;
            target    <= 32'h0;
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
            perf_q    <= '0;
        end else begin
            if (flush_req) begin
                target    <= flush_pc_in;
                flush_cnt <= FLUSH_LOAD;
                state     <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            end else if (state == FLUSH) begin
                if (flush_cnt <= 4'd1)
                    state <= RUN;
                else
                    flush_cnt <= flush_cnt - 4'd1;
            end else if (stall != 6'b000000) begin
                state <= STALL;
            end else begin
                state <= RUN;
            end

            if (stall == 6'b000000) begin
                wd_cnt <= '0;
            end else begin
                if (wd_cnt != WD_W'(STALL_TIMEOUT))
                    wd_cnt <= wd_cnt + 1'b1;
                if (wd_cnt == WD_W'(STALL_TIMEOUT - 1))
                    timeout_q <= 1'b1;
            end

            if (stall != 6'b000000 && perf_q != '1)
                perf_q <= perf_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a behavioural model pushes expected outputs
// per driven cycle into a scoreboard queue that is popped when the DUT outputs settle.
module tb_pipe_ctrl;

    localparam int FC  = 3;
    localparam int TO  = 8;
    localparam int CW  = 4;

    typedef struct {
        logic [5:0]    stall;
        logic          flush;
        logic [31:0]   pc;
        logic          to;
        logic [CW-1:0] perf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stallreq_id = 1'b0;
    logic          stallreq_ex = 1'b0;
    logic          stallreq_mem = 1'b0;
    logic          flush_req = 1'b0;
    logic [31:0]   flush_pc_in = 32'h0;
    logic [5:0]    stall;
    logic          flush;
    logic [31:0]   new_pc;
    logic          stall_timeout;
    logic [CW-1:0] perf_stall_cnt;

    int checks = 0;
    int errors = 0;

    exp_t scoreboard[$];

    int            m_flush_left = 0;
    logic [31:0]   m_target = 32'h0;
    int            m_wd = 0;
    logic          m_to = 1'b0;
    int            m_perf = 0;

    pipe_ctrl #(.FLUSH_CYCLES(FC), .STALL_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .flush_req(flush_req), .flush_pc_in(flush_pc_in),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .stall_timeout(stall_timeout), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Drive one cycle of inputs, predict outputs, then compare once they settle.
    task automatic apply_stimulus(input logic r, input logic id, input logic ex, input logic mem,
                                  input logic fr, input logic [31:0] pc, input string tag);
        exp_t e;
        exp_t got;
        logic flushing;
        @(negedge clk);
        rst = r; stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
        flush_req = fr; flush_pc_in = pc;

        e.stall = 6'b0; e.flush = 1'b0; e.pc = 32'h0; e.to = 1'b0; e.perf = '0;
        if (!r) begin
            flushing = fr || (m_flush_left > 0);
            e.flush  = flushing;
            if (!flushing)
                e.stall = mem ? 6'h1F : ex ? 6'h0F : id ? 6'h07 : 6'h00;
            e.pc   = fr ? pc : (m_flush_left > 0) ? m_target : 32'h0;
            e.to   = m_to;
            e.perf = CW'(m_perf);
        end
        scoreboard.push_back(e);

        if (r) begin
            m_flush_left = 0; m_target = 32'h0; m_wd = 0; m_to = 1'b0; m_perf = 0;
        end else begin
            if (fr) begin
                m_flush_left = FC - 1;
                m_target     = pc;
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end
            if (e.stall != 6'b0) begin
                m_wd++;
                if (m_wd == TO) m_to = 1'b1;
                if (m_perf < (1 << CW) - 1) m_perf++;
            end else begin
                m_wd = 0;
            end
        end

        #2;
        got = scoreboard.pop_front();
        check_output({tag, ".stall"}, 64'(stall), 64'(got.stall));
        check_output({tag, ".flush"}, 64'(flush), 64'(got.flush));
        check_output({tag, ".new_pc"}, 64'(new_pc), 64'(got.pc));
        check_output({tag, ".timeout"}, 64'(stall_timeout), 64'(got.to));
        check_output({tag, ".perf"}, 64'(perf_stall_cnt), 64'(got.perf));
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, 32'h0, tag);
    endtask

    task automatic hold_stall(input int n, input logic id, input logic ex, input logic mem,
                              input string tag);
        for (int i = 0; i < n; i++) apply_stimulus(0, id, ex, mem, 0, 32'h0, tag);
    endtask

    initial begin
        // Reset with every request asserted
        apply_stimulus(1, 1, 1, 1, 1, 32'hDEAD_BEEF, "t1_rst");
        apply_stimulus(1, 1, 1, 1, 1, 32'hDEAD_BEEF, "t1_rst");
        idle(1, "t1_idle");

        // Priority build-up and release
        apply_stimulus(0, 1, 0, 0, 0, 32'h0, "t2_id");
        apply_stimulus(0, 1, 1, 0, 0, 32'h0, "t2_ex");
        apply_stimulus(0, 1, 1, 1, 0, 32'h0, "t2_mem");
        apply_stimulus(0, 0, 0, 0, 0, 32'h0, "t2_drop");
        idle(1, "t2_cnt");
        apply_stimulus(0, 0, 1, 0, 0, 32'h0, "t2_exonly");
        apply_stimulus(0, 1, 0, 1, 0, 32'h0, "t2_idmem");
        idle(1, "t2_idle");

        // Flush over stall, held for FC cycles, then stall resumes
        apply_stimulus(0, 0, 0, 1, 1, 32'h0000_0040, "t3_flush");
        hold_stall(2, 0, 0, 1, "t3_hold");
        hold_stall(1, 0, 0, 1, "t3_after");
        idle(1, "t3_idle");

        // Flush request during an active flush reloads target and length
        apply_stimulus(0, 0, 0, 0, 1, 32'h0000_0100, "t3_f1");
        apply_stimulus(0, 1, 0, 0, 1, 32'h0000_0200, "t3_f2");
        hold_stall(2, 1, 0, 0, "t3_f2hold");
        idle(2, "t3_f2end");

        // Reset in the middle of a flush drops the target
        apply_stimulus(0, 0, 0, 0, 1, 32'h0000_0300, "t_midrst_f");
        apply_stimulus(1, 0, 1, 0, 0, 32'h0, "t_midrst_r");
        idle(2, "t_midrst_idle");

        // Watchdog: 7 cycles is short of the limit, 8 trips it, it then sticks
        hold_stall(7, 0, 1, 0, "t4_7");
        idle(1, "t4_7idle");
        hold_stall(8, 0, 1, 0, "t4_8");
        idle(1, "t4_8idle");
        hold_stall(5, 0, 1, 0, "t4_5");
        idle(1, "t4_5idle");
        apply_stimulus(1, 0, 0, 0, 0, 32'h0, "t4_rst");
        idle(1, "t4_cleared");

        // Watchdog clears on an idle cycle between stalls
        hold_stall(6, 0, 1, 0, "t5_a");
        idle(1, "t5_gap");
        hold_stall(6, 1, 0, 0, "t5_b");
        idle(1, "t5_end");

        // A flush breaks a stall run for the watchdog too
        apply_stimulus(1, 0, 0, 0, 0, 32'h0, "t5_rst");
        hold_stall(5, 0, 0, 1, "t5_c");
        apply_stimulus(0, 0, 0, 1, 1, 32'h0000_0080, "t5_fl");
        hold_stall(7, 0, 0, 1, "t5_d");
        idle(1, "t5_dend");

        // Perf counter saturation
        apply_stimulus(1, 0, 0, 0, 0, 32'h0, "t6_rst");
        hold_stall(20, 1, 0, 0, "t6_sat");
        idle(2, "t6_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
